// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM encoding, BCD limits,
// board-rate defaults and small digit helpers.
package countdown_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_HIGH_MAX = 4'd5;

    // 50 MHz board clock: 10 ms tick and 20 ms debounce window
    localparam int DEFAULT_TICK_DIV        = 500000;
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Saturate a preset digit coming from the switches to its legal maximum
    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Largest legal value of digit position i (0 = csec_low .. 5 = min_high)
    function automatic logic [3:0] digit_wrap(input int i);
        return (i == 3) ? SEC_HIGH_MAX : DIGIT_MAX;
    endfunction

endpackage

// File: rtl/countdown_timer_key_debounce.sv
// Raw active-low key to single-cycle press pulse: two-flop synchronizer,
// then a stable-level counter that fires once per press and re-arms only
// after the key has been released for the same stable window.
module key_debounce
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          armed;
    logic [CW-1:0] stable_cnt;

    // Bring the asynchronous key into the clock domain; idle level is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Armed waits for a stable low (press), disarmed waits for a stable high (release)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b1;
            stable_cnt <= '0;
            press      <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync2 != armed) begin
                if (stable_cnt == LAST) begin
                    stable_cnt <= '0;
                    armed      <= ~armed;
                    press      <= armed;
                end else begin
                    stable_cnt <= stable_cnt + CW'(1);
                end
            end else begin
                stable_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/countdown_timer.sv
// MM:SS.cc countdown timer: loads a clamped BCD preset, counts down once
// per tick with a cascaded BCD borrow, and raises alarm on reaching zero.
module countdown_timer
    import countdown_pkg::*;
#(
    parameter int TICK_DIV        = DEFAULT_TICK_DIV,
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       key_reset,
    input  logic       key_start_pause,
    input  logic       key_load,
    input  logic [3:0] preset_min_high,
    input  logic [3:0] preset_min_low,
    input  logic [3:0] preset_sec_high,
    input  logic [3:0] preset_sec_low,
    output logic [3:0] min_high,
    output logic [3:0] min_low,
    output logic [3:0] sec_high,
    output logic [3:0] sec_low,
    output logic [3:0] csec_high,
    output logic [3:0] csec_low,
    output logic       running,
    output logic       alarm
);

    localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t          state;
    state_t          state_next;
    logic            start_press;
    logic            load_press;
    logic            load_now;
    logic            tick;
    logic            borrow;
    logic            is_zero;
    logic            dec_zero;
    logic [TW-1:0]   tick_cnt;
    logic [5:0][3:0] digits;
    logic [5:0][3:0] dec_digits;
    logic [5:0][3:0] preset_digits;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk     (clk),
        .rst_n   (key_reset),
        .key_raw (key_start_pause),
        .press   (start_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
        .clk     (clk),
        .rst_n   (key_reset),
        .key_raw (key_load),
        .press   (load_press)
    );

    assign tick          = (state == RUN) && (tick_cnt == TICK_LAST);
    assign is_zero       = (digits == '0);
    assign dec_zero      = (dec_digits == '0);
    assign preset_digits = {clamp_digit(preset_min_high, DIGIT_MAX),
                            clamp_digit(preset_min_low,  DIGIT_MAX),
                            clamp_digit(preset_sec_high, SEC_HIGH_MAX),
                            clamp_digit(preset_sec_low,  DIGIT_MAX),
                            8'h00};

    // Value minus one centisecond, borrowing up the chain from csec_low
    always_comb begin
        dec_digits = digits;
        borrow     = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (borrow) begin
                if (digits[i] == 4'd0) begin
                    dec_digits[i] = digit_wrap(i);
                end else begin
                    dec_digits[i] = digits[i] - 4'd1;
                    borrow        = 1'b0;
                end
            end
        end
    end

    // Next state; load beats start everywhere except RUN, where load is ignored
    always_comb begin
        state_next = state;
        load_now   = 1'b0;
        case (state)
            IDLE: begin
                if (load_press)                    load_now   = 1'b1;
                else if (start_press && !is_zero)  state_next = RUN;
            end
            RUN: begin
                if (tick && dec_zero)              state_next = DONE;
                else if (start_press)              state_next = PAUSE;
            end
            PAUSE: begin
                if (load_press)                    load_now   = 1'b1;
                else if (start_press)              state_next = RUN;
            end
            DONE: begin
                if (load_press)                    load_now   = 1'b1;
            end
            default: state_next = IDLE;
        endcase
        if (load_now) state_next = IDLE;
    end

    // State register with status lines decoded from the next state
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            state   <= IDLE;
            running <= 1'b0;
            alarm   <= 1'b0;
        end else begin
            state   <= state_next;
            running <= (state_next == RUN);
            alarm   <= (state_next == DONE);
        end
    end

    // Tick divider advances only while running and holds otherwise
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            tick_cnt <= '0;
        end else if (load_now) begin
            tick_cnt <= '0;
        end else if (state == RUN) begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
        end
    end

    // Digit register: preset on load, decrement on tick, never below zero
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            digits <= '0;
        end else if (load_now) begin
            digits <= preset_digits;
        end else if (tick && !is_zero) begin
            digits <= dec_digits;
        end
    end

    assign min_high  = digits[5];
    assign min_low   = digits[4];
    assign sec_high  = digits[3];
    assign sec_low   = digits[2];
    assign csec_high = digits[1];
    assign csec_low  = digits[0];

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer with a short tick and
// debounce window; every expected value below is worked out by hand.
module tb_countdown_timer;

    localparam int TICK_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PAUSE = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic       clk = 1'b0;
    logic       key_reset;
    logic       key_start_pause;
    logic       key_load;
    logic [3:0] preset_min_high, preset_min_low, preset_sec_high, preset_sec_low;
    logic [3:0] min_high, min_low, sec_high, sec_low, csec_high, csec_low;
    logic       running;
    logic       alarm;
    logic [23:0] disp;

    int vectors     = 0;
    int miscompares = 0;

    countdown_timer #(.TICK_DIV(TICK_DIV), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) dut (
        .clk             (clk),
        .key_reset       (key_reset),
        .key_start_pause (key_start_pause),
        .key_load        (key_load),
        .preset_min_high (preset_min_high),
        .preset_min_low  (preset_min_low),
        .preset_sec_high (preset_sec_high),
        .preset_sec_low  (preset_sec_low),
        .min_high        (min_high),
        .min_low         (min_low),
        .sec_high        (sec_high),
        .sec_low         (sec_low),
        .csec_high       (csec_high),
        .csec_low        (csec_low),
        .running         (running),
        .alarm           (alarm)
    );

    assign disp = {min_high, min_low, sec_high, sec_low, csec_high, csec_low};

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Call on a falling edge: hold the selected keys low for low_cycles, then release
    task automatic applyStimulus(input logic ld, input logic st, input int low_cycles);
        key_load        = ~ld;
        key_start_pause = ~st;
        repeat (low_cycles) @(negedge clk);
        key_load        = 1'b1;
        key_start_pause = 1'b1;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic setPreset(input logic [15:0] p);
        {preset_min_high, preset_min_low, preset_sec_high, preset_sec_low} = p;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        key_reset       = 1'b0;
        key_start_pause = 1'b1;
        key_load        = 1'b1;
        setPreset(16'h0000);
        waitCycles(3);
        key_reset = 1'b1;
        waitCycles(2);
        $display("[TB] reset state");
        checkOutput("rst_digits",  32'(disp), 32'h0);
        checkOutput("rst_state",   32'(dut.state), 32'(S_IDLE));
        checkOutput("rst_running", 32'(running), 32'd0);
        checkOutput("rst_alarm",   32'(alarm), 32'd0);
        checkOutput("rst_tickcnt", 32'(dut.tick_cnt), 32'd0);

        $display("[TB] debounce");
        applyStimulus(1'b0, 1'b1, 5);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            checkOutput("db_short", 32'(dut.start_press), 32'd0);
        end
        key_start_pause = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 9)  checkOutput("db_pre",   32'(dut.start_press), 32'd0);
            if (k == 10) checkOutput("db_pulse", 32'(dut.start_press), 32'd1);
            if (k == 11) checkOutput("db_post",  32'(dut.start_press), 32'd0);
        end
        key_start_pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("db_glitch_hi", 32'(dut.start_press), 32'd0);
        end
        key_start_pause = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checkOutput("db_glitch_lo", 32'(dut.start_press), 32'd0);
        end
        key_start_pause = 1'b1;
        checkOutput("idle_zero_start", 32'(dut.state), 32'(S_IDLE));
        waitCycles(12);

        $display("[TB] load clamp");
        setPreset(16'hA76F);
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("clamp_digits", 32'(disp), 32'h975900);
        checkOutput("clamp_state",  32'(dut.state), 32'(S_IDLE));
        waitCycles(12);

        $display("[TB] borrow chain");
        setPreset(16'h0100);
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("load_0100", 32'(disp), 32'h010000);
        waitCycles(12);
        applyStimulus(1'b0, 1'b1, 12);
        checkOutput("run_running", 32'(running), 32'd1);
        waitCycles(3);
        checkOutput("borrow_1", 32'(disp), 32'h005999);
        waitCycles(16);
        checkOutput("borrow_5", 32'(disp), 32'h005995);

        $display("[TB] pause and resume");
        waitCycles(3);
        applyStimulus(1'b0, 1'b1, 12);
        checkOutput("pause_state",   32'(dut.state), 32'(S_PAUSE));
        checkOutput("pause_running", 32'(running), 32'd0);
        checkOutput("pause_digits",  32'(disp), 32'h005992);
        checkOutput("pause_tickcnt", 32'(dut.tick_cnt), 32'd2);
        waitCycles(50);
        checkOutput("hold_digits",  32'(disp), 32'h005992);
        checkOutput("hold_tickcnt", 32'(dut.tick_cnt), 32'd2);
        applyStimulus(1'b0, 1'b1, 12);
        checkOutput("resume_running", 32'(running), 32'd1);
        checkOutput("resume_digits",  32'(disp), 32'h005992);
        waitCycles(1);
        checkOutput("resume_tick", 32'(disp), 32'h005991);
        waitCycles(12);
        applyStimulus(1'b0, 1'b1, 12);
        checkOutput("pause2_state", 32'(dut.state), 32'(S_PAUSE));
        waitCycles(12);
        setPreset(16'h1234);
        applyStimulus(1'b1, 1'b1, 12);
        checkOutput("prio_digits", 32'(disp), 32'h123400);
        checkOutput("prio_state",  32'(dut.state), 32'(S_IDLE));
        waitCycles(12);

        $display("[TB] zero and alarm");
        setPreset(16'h0001);
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("load_0001", 32'(disp), 32'h000100);
        waitCycles(12);
        applyStimulus(1'b0, 1'b1, 12);
        waitCycles(398);
        checkOutput("pre_zero_digits", 32'(disp), 32'h000001);
        checkOutput("pre_zero_alarm",  32'(alarm), 32'd0);
        waitCycles(1);
        checkOutput("zero_digits",  32'(disp), 32'h0);
        checkOutput("zero_alarm",   32'(alarm), 32'd1);
        checkOutput("zero_running", 32'(running), 32'd0);
        checkOutput("zero_state",   32'(dut.state), 32'(S_DONE));
        waitCycles(12);
        applyStimulus(1'b0, 1'b1, 12);
        checkOutput("done_start_state", 32'(dut.state), 32'(S_DONE));
        checkOutput("done_start_alarm", 32'(alarm), 32'd1);
        waitCycles(12);
        applyStimulus(1'b1, 1'b0, 12);
        checkOutput("done_load_alarm",  32'(alarm), 32'd0);
        checkOutput("done_load_state",  32'(dut.state), 32'(S_IDLE));
        checkOutput("done_load_digits", 32'(disp), 32'h000100);
        waitCycles(12);

        $display("[TB] reset mid-run");
        applyStimulus(1'b0, 1'b1, 12);
        waitCycles(4);
        checkOutput("mid_run_digits", 32'(disp), 32'h000099);
        #2;
        key_reset = 1'b0;
        #1;
        checkOutput("async_digits",  32'(disp), 32'h0);
        checkOutput("async_state",   32'(dut.state), 32'(S_IDLE));
        checkOutput("async_running", 32'(running), 32'd0);
        checkOutput("async_alarm",   32'(alarm), 32'd0);
        @(negedge clk);
        key_reset = 1'b1;
        @(negedge clk);
        checkOutput("release_tickcnt", 32'(dut.tick_cnt), 32'd0);
        checkOutput("release_state",   32'(dut.state), 32'(S_IDLE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
